// File: rtl/pdp8_tt_uart.sv
// Serial line stage for the PDP-8 console TTY: 8N1/8N2 transmitter and 8N1 receiver
// sharing one free-running 16x oversample tick. FSM states are exposed on tx_state/rx_state.
//
// Handshakes: tx_load is taken only while tx_busy=0 (a load is also taken in the tx_done
// cycle, where tx_busy already reads 0). rx_full is the "valid" for rx_data and rx_ack
// consumes it. A completion that coincides with rx_ack takes priority.
module pdp8_tt_uart #(
  parameter int DIV       = 27,
  parameter int STOP_BITS = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_load,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       txd,
  input  logic       rxd,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_full,
  output logic       rx_ferr,
  output logic       rx_overrun,
  output logic [1:0] tx_state,
  output logic [1:0] rx_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam int            CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  logic [CW-1:0] div_cnt;
  logic          tick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) div_cnt <= '0;
    else          div_cnt <= tick ? '0 : div_cnt + 1'b1;
  end

  assign tick = (div_cnt == DIV_LAST);

  // ---------------- transmitter ----------------
  logic       tx_wait;
  logic [3:0] tx_tcnt;
  logic [2:0] tx_bcnt;
  logic [7:0] tx_sh;
  logic       tx_fin;
  logic       tx_accept;

  assign tx_fin    = (tx_state == STOP) && tick && (tx_tcnt == 4'd15) && (tx_bcnt == STOP_LAST);
  assign tx_done   = tx_fin;
  assign tx_busy   = (tx_state != IDLE) && !tx_fin;
  assign tx_accept = tx_load && !tx_busy;

  // tx_wait holds the line at mark until the first tick so every bit is exactly 16 ticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= IDLE;
      tx_wait  <= 1'b0;
      tx_tcnt  <= '0;
      tx_bcnt  <= '0;
      tx_sh    <= '0;
      txd      <= 1'b1;
    end else if (tx_accept) begin
      tx_state <= START;
      tx_sh    <= tx_data;
      tx_tcnt  <= '0;
      tx_bcnt  <= '0;
      if (tick) begin
        txd     <= 1'b0;
        tx_wait <= 1'b0;
      end else begin
        tx_wait <= 1'b1;
      end
    end else if (tx_state != IDLE && tick) begin
      if (tx_wait) begin
        txd     <= 1'b0;
        tx_wait <= 1'b0;
      end else if (tx_tcnt != 4'd15) begin
        tx_tcnt <= tx_tcnt + 1'b1;
      end else begin
        tx_tcnt <= '0;
        case (tx_state)
          START: begin
            tx_state <= DATA;
            tx_bcnt  <= '0;
            txd      <= tx_sh[0];
            tx_sh    <= {1'b0, tx_sh[7:1]};
          end
          DATA: begin
            if (tx_bcnt == 3'd7) begin
              tx_state <= STOP;
              tx_bcnt  <= '0;
              txd      <= 1'b1;
            end else begin
              tx_bcnt <= tx_bcnt + 1'b1;
              txd     <= tx_sh[0];
              tx_sh   <= {1'b0, tx_sh[7:1]};
            end
          end
          STOP: begin
            if (tx_bcnt == STOP_LAST) tx_state <= IDLE;
            else                      tx_bcnt  <= tx_bcnt + 1'b1;
          end
          default: tx_state <= IDLE;
        endcase
      end
    end
  end

  // ---------------- receiver ----------------
  logic       rx_s1, rx_s2, rx_s3;
  logic [3:0] rx_tcnt;
  logic [2:0] rx_bcnt;
  logic [7:0] rx_sh;
  logic       rx_done;

  assign rx_done = (rx_state == STOP) && tick && (rx_tcnt == 4'd15);

  // Synchronizer flops reset to mark so release of reset never looks like a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_s3      <= 1'b1;
      rx_state   <= IDLE;
      rx_tcnt    <= '0;
      rx_bcnt    <= '0;
      rx_sh      <= '0;
      rx_data    <= '0;
      rx_full    <= 1'b0;
      rx_ferr    <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      case (rx_state)
        IDLE: begin
          if (rx_s3 && !rx_s2) begin
            rx_state <= START;
            rx_tcnt  <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (rx_tcnt == 4'd7) begin
              rx_tcnt  <= '0;
              rx_bcnt  <= '0;
              rx_state <= rx_s2 ? IDLE : DATA;
            end else begin
              rx_tcnt <= rx_tcnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (rx_tcnt == 4'd15) begin
              rx_tcnt <= '0;
              rx_sh   <= {rx_s2, rx_sh[7:1]};
              if (rx_bcnt == 3'd7) rx_state <= STOP;
              else                 rx_bcnt  <= rx_bcnt + 1'b1;
            end else begin
              rx_tcnt <= rx_tcnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (rx_tcnt == 4'd15) rx_state <= IDLE;
            else                  rx_tcnt  <= rx_tcnt + 1'b1;
          end
        end
        default: rx_state <= IDLE;
      endcase

      // An rx_ack in the completion cycle frees the holding register for the new byte.
      if (rx_done) begin
        if (rx_full && !rx_ack) begin
          rx_overrun <= 1'b1;
        end else begin
          rx_data    <= rx_sh;
          rx_full    <= 1'b1;
          rx_ferr    <= !rx_s2;
          rx_overrun <= 1'b0;
        end
      end else if (rx_ack) begin
        rx_full    <= 1'b0;
        rx_ferr    <= 1'b0;
        rx_overrun <= 1'b0;
      end
    end
  end

endmodule
